cdc_handshake_arbiter: RTL and testbench

- Shares one 4-phase req/ack clock-domain-crossing channel among NUM_REQ requesters in the source domain.
- Round-robin arbitration picks a requester. Its data word and ID are captured and held stable on the crossing bus.
- Sequences xd_req against the far-domain acknowledge. xd_ack is asynchronous and is brought into clk through an internal multi-flop synchronizer.
- Sits at the source side of every multi-bit control/status crossing.

---
 rtl/cdc_handshake_arbiter_pkg.sv | 49 ++++
 rtl/synchronizer_ff.sv | 41 ++++
 rtl/cdc_handshake_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_cdc_handshake_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_handshake_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdc_hs_pkg
//   Shared types and helpers for cdc_handshake_arbiter.
//   - hs_state_e : handshake FSM states (IDLE -> REQ -> RELEASE -> IDLE).
//   - rr_pick()  : round-robin scan over a request vector starting at a
//                  pointer; returns a found flag and the granted index.
// -----------------------------------------------------------------------------
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_REQ     = 2'd1,
    HS_RELEASE = 2'd2
  } hs_state_e;

  // Upper bound on requesters the helper can scan. Callers zero-extend their
  // request vector to this width and pass their real count in num_req.
  localparam int unsigned RR_MAX_REQ = 32;
  localparam int unsigned RR_IDX_W   = $clog2(RR_MAX_REQ);

  // Scan ptr, ptr+1, ... (mod num_req) and return the first set bit.
  // ptr must be < num_req, so one conditional subtraction replaces the modulo.
  // With num_req constant at the call site the loop folds to a priority mux.
  function automatic logic rr_pick(
    input  logic [RR_MAX_REQ-1:0] valid,
    input  int unsigned           ptr,
    input  int unsigned           num_req,
    output int unsigned           idx
  );
    logic        found;
    int unsigned cand;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      if (i < num_req) begin
        cand = ptr + i;
        if (cand >= num_req) begin
          cand = cand - num_req;
        end
        if (!found && valid[cand[RR_IDX_W-1:0]]) begin
          found = 1'b1;
          idx   = cand;
        end
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/synchronizer_ff.sv
// -----------------------------------------------------------------------------
// synchronizer_ff
//   Plain multi-flop synchronizer for signals arriving from another clock
//   domain. The flops carry no reset so that nothing but the clock touches the
//   metastability chain.
// Ports:
//   clk : destination-domain clock
//   d   : asynchronous input   [DATA_WIDTH]
//   q   : synchronized output  [DATA_WIDTH], SYNC_DEPTH cycles of latency
// -----------------------------------------------------------------------------
module synchronizer_ff #(
  parameter int DATA_WIDTH = 1,
  parameter int SYNC_DEPTH = 2
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] stage_q [SYNC_DEPTH];
  logic [DATA_WIDTH-1:0] stage_d [SYNC_DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < SYNC_DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        stage_q[gi] <= stage_d[gi];
      end
    end
  endgenerate

  assign q = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/cdc_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_handshake_arbiter
//   Source side of a 4-phase req/ack crossing shared by NUM_REQ requesters.
//   A round-robin arbiter picks one requester while idle, latches its payload
//   and index onto the crossing bus, raises xd_req, waits for the synchronized
//   acknowledge, drops xd_req, waits for the acknowledge to fall and reports
//   completion with a one-cycle done pulse.
//
// Build option:
//   CDC_HS_TIMEOUT_EN - adds a per-phase watchdog of TIMEOUT_CYCLES cycles and
//                       the timeout output. Without it the FSM waits forever.
//
// Ports:
//   clk        in   source-domain clock
//   rst        in   synchronous active-high reset
//   req_valid  in   [NUM_REQ] per-requester request, held until req_ready
//   req_data   in   [NUM_REQ*DATA_WIDTH] payloads, requester i at i*DATA_WIDTH
//   req_ready  out  [NUM_REQ] one-hot accept pulse (combinational, grant cycle)
//   xd_req     out  crossing request (registered)
//   xd_data    out  [DATA_WIDTH] crossing payload, changes only on grant
//   xd_id      out  [$clog2(NUM_REQ)] index of the granted requester
//   xd_ack     in   far-domain acknowledge, asynchronous to clk
//   busy       out  high while the FSM is outside IDLE
//   done       out  one-cycle pulse on handshake completion
//   done_id    out  [$clog2(NUM_REQ)] id of the completed transfer
//   timeout    out  one-cycle watchdog pulse (CDC_HS_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module cdc_handshake_arbiter
  import cdc_hs_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          xd_req,
  output logic [DATA_WIDTH-1:0]         xd_data,
  output logic [$clog2(NUM_REQ)-1:0]    xd_id,
  input  logic                          xd_ack,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_REQ)-1:0]    done_id
`ifdef CDC_HS_TIMEOUT_EN
  ,
  output logic                          timeout
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Reject parameter sets the logic below cannot handle.
  generate
    if (NUM_REQ < 2 || NUM_REQ > int'(RR_MAX_REQ) || SYNC_DEPTH < 2 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("cdc_handshake_arbiter: unsupported parameter set");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Acknowledge synchronizer
  // ---------------------------------------------------------------------------
  logic ack_s;

  synchronizer_ff #(
    .DATA_WIDTH (1),
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_ack_sync (
    .clk (clk),
    .d   (xd_ack),
    .q   (ack_s)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  hs_state_e             state_q,   state_d;
  logic [ID_W-1:0]       rr_ptr_q,  rr_ptr_d;
  logic                  xd_req_q,  xd_req_d;
  logic [DATA_WIDTH-1:0] xd_data_q, xd_data_d;
  logic [ID_W-1:0]       xd_id_q,   xd_id_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic [ID_W-1:0]       done_id_q, done_id_d;
  logic [NUM_REQ-1:0]    req_ready_c;

`ifdef CDC_HS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  timeout_q, timeout_d;
`endif

  logic [RR_MAX_REQ-1:0] valid_ext;
  logic                  grant_found;
  int unsigned           pick_idx;

  assign valid_ext = RR_MAX_REQ'(req_valid);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    xd_data_d   = xd_data_q;
    xd_id_d     = xd_id_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    req_ready_c = '0;
`ifdef CDC_HS_TIMEOUT_EN
    timeout_d   = 1'b0;
`endif

    grant_found = rr_pick(valid_ext, 32'(rr_ptr_q), NUM_REQ, pick_idx);

    case (state_q)
      HS_IDLE: begin
        // A still-high ack_s means the far side has not yet released a
        // handshake we abandoned (reset or watchdog); starting a new one now
        // would be read as already acknowledged.
        if (!ack_s && grant_found) begin
          req_ready_c = NUM_REQ'(1) << pick_idx;
          xd_data_d   = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          xd_id_d     = ID_W'(pick_idx);
          if (pick_idx == NUM_REQ - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = ID_W'(pick_idx + 1);
          end
          state_d = HS_REQ;
        end
      end

      HS_REQ: begin
        if (ack_s) begin
          state_d = HS_RELEASE;
        end
`ifdef CDC_HS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = HS_IDLE;
        end
`endif
      end

      HS_RELEASE: begin
        if (!ack_s) begin
          state_d   = HS_IDLE;
          done_d    = 1'b1;
          done_id_d = xd_id_q;
        end
`ifdef CDC_HS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = HS_IDLE;
        end
`endif
      end

      default: begin
        state_d = HS_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the state
    // register instead of lagging it by a cycle.
    xd_req_d = (state_d == HS_REQ);
    busy_d   = (state_d != HS_IDLE);

`ifdef CDC_HS_TIMEOUT_EN
    // Restart on every phase change so each phase gets the full budget.
    if (state_d != state_q || state_q == HS_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HS_IDLE;
      rr_ptr_q  <= '0;
      xd_req_q  <= 1'b0;
      xd_data_q <= '0;
      xd_id_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
`ifdef CDC_HS_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      xd_req_q  <= xd_req_d;
      xd_data_q <= xd_data_d;
      xd_id_q   <= xd_id_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
`ifdef CDC_HS_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The accept pulse is combinational so a requester sees it in the cycle its
  // payload is captured; it is masked during reset because nothing is captured.
  assign req_ready = rst ? '0 : req_ready_c;
  assign xd_req    = xd_req_q;
  assign xd_data   = xd_data_q;
  assign xd_id     = xd_id_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
`ifdef CDC_HS_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_arbiter
//   Scoreboard bench: each observed grant is checked against a round-robin
//   reference and pushed (id, payload) onto a queue; each done pops the queue.
//   A far-side model answers xd_req after ACK_DLY cycles and releases xd_ack
//   REL_DLY cycles after xd_req falls, unless manual ack control is selected.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int SYNC_DEPTH = 2;
  localparam int TO_CYCLES  = 16;
  localparam int ACK_DLY    = 3;
  localparam int REL_DLY    = 3;

  typedef struct {
    int             id;
    logic [7:0]     data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        xd_req;
  logic [7:0]  xd_data;
  logic [1:0]  xd_id;
  logic        xd_ack;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
`ifdef CDC_HS_TIMEOUT_EN
  logic        timeout;
`endif

  always #5 clk = ~clk;

  cdc_handshake_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_WIDTH     (DATA_WIDTH),
    .SYNC_DEPTH     (SYNC_DEPTH),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .xd_req    (xd_req),
    .xd_data   (xd_data),
    .xd_id     (xd_id),
    .xd_ack    (xd_ack),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id)
`ifdef CDC_HS_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  int    checks = 0;
  int    errors = 0;
  xfer_t exp_q[$];
  int    grant_log[$];
  int    exp_ptr = 0;
  int    n_grant = 0;
  int    n_done = 0;
  int    n_to = 0;
  int    cyc = 0;
  int    rise_cyc = 0;
  int    req_len = 0;
  int    last_g = -1;
  int    last_id = 0;
  logic [7:0] last_data = '0;
  int    pend_drop = -1;
  int    ack_cnt = 0;
  bit    auto_ack = 1'b1;
  bit    drop_on_ready = 1'b1;
  bit    check_len = 1'b0;
  bit    check_stable = 1'b0;
  bit    check_repeat = 1'b0;
  bit    expect_no_grant = 1'b0;
  logic  prev_xd_req = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference round-robin choice.
  function automatic bit rr_model(input logic [3:0] v, input int ptr, output int g);
    g = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (v[idx]) begin
        g = idx;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock: sample the combinational accept just after the inputs settle,
  // then move to the next falling edge and examine the registered outputs.
  task automatic step();
    int g;
    bit found;
    #1;
    if (req_ready !== 4'b0000) begin
      if (rst || expect_no_grant) begin
        check_eq("unexpected_ready", req_ready, 0);
      end else begin
        found = rr_model(req_valid, exp_ptr, g);
        check_eq("grant_onehot", req_ready, found ? (32'd1 << g) : 32'd0);
        if (found) begin
          if (check_repeat && last_g >= 0) check_eq("rr_repeat", (g == last_g), 0);
          exp_q.push_back('{id: g, data: req_data[g*8 +: 8]});
          grant_log.push_back(g);
          last_id   = g;
          last_data = req_data[g*8 +: 8];
          last_g    = g;
          exp_ptr   = (g + 1) % NUM_REQ;
          n_grant++;
          if (drop_on_ready) pend_drop = g;
        end
      end
    end

    @(negedge clk);
    cyc++;
    if (pend_drop >= 0) begin
      req_valid[pend_drop] = 1'b0;
      pend_drop = -1;
    end

    if (xd_req && !prev_xd_req) begin
      check_eq("xd_data_at_req", xd_data, last_data);
      check_eq("xd_id_at_req", xd_id, last_id);
      check_eq("busy_at_req", busy, 1);
      rise_cyc = cyc;
      req_len  = 0;
    end
    if (xd_req) req_len++;
    if (!xd_req && prev_xd_req && check_len) check_eq("xd_req_len", req_len, ACK_DLY + SYNC_DEPTH);
    if (check_stable && busy) check_eq("xd_data_stable", xd_data, last_data);

    if (done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", done, 0);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        check_eq("done_id", done_id, e.id);
        check_eq("xd_data_at_done", xd_data, e.data);
        check_eq("busy_at_done", busy, 0);
        $display("xfer id=%0d data=%02h cycle=%0d", e.id, e.data, cyc);
      end
      n_done++;
    end

`ifdef CDC_HS_TIMEOUT_EN
    if (timeout) begin
      check_eq("timeout_latency", cyc - rise_cyc, TO_CYCLES);
      check_eq("timeout_xd_req", xd_req, 0);
      check_eq("timeout_busy", busy, 0);
      if (exp_q.size() != 0) begin
        xfer_t e;
        e = exp_q.pop_front();
        $display("xfer id=%0d data=%02h abandoned by watchdog cycle=%0d", e.id, e.data, cyc);
      end
      n_to++;
    end
`endif
    prev_xd_req = xd_req;

    if (auto_ack) begin
      if (xd_req && !xd_ack) begin
        ack_cnt++;
        if (ack_cnt == ACK_DLY) begin xd_ack = 1'b1; ack_cnt = 0; end
      end else if (!xd_req && xd_ack) begin
        ack_cnt++;
        if (ack_cnt == REL_DLY) begin xd_ack = 1'b0; ack_cnt = 0; end
      end else begin
        ack_cnt = 0;
      end
    end
  endtask

  task automatic wait_dones(input int target, input string tag);
    int k = 0;
    while (n_done < target && k < 200) begin step(); k++; end
    check_eq(tag, n_done, target);
  endtask

  task automatic wait_grants(input int target, input string tag);
    int k = 0;
    while (n_grant < target && k < 200) begin step(); k++; end
    check_eq(tag, n_grant, target);
  endtask

  task automatic clear_after_reset();
    exp_q.delete();
    exp_ptr = 0;
    last_g  = -1;
  endtask

  initial begin : main
    int base;
    int k;
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};

    rst = 1'b1; req_valid = 4'hF; req_data = 32'h5A5A5A5A; xd_ack = 1'b0;
    repeat (3) step();
    // Reset state, with every requester asking: nothing may be accepted.
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_xd_req", xd_req, 0);
    check_eq("rst_xd_data", xd_data, 0);
    check_eq("rst_xd_id", xd_id, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_done_id", done_id, 0);
`ifdef CDC_HS_TIMEOUT_EN
    check_eq("rst_timeout", timeout, 0);
`endif
    req_valid = 4'h0; req_data = 32'h0;
    rst = 1'b0;
    clear_after_reset();
    step();

    // Single request from requester 2.
    req_data[23:16] = 8'hA5; req_valid = 4'b0100; check_len = 1'b1;
    wait_dones(1, "t1_done");
    check_len = 1'b0;
    repeat (3) step();
    check_eq("t1_grant_count", n_grant, 1);
    check_eq("t1_xd_id_held", xd_id, 2);
    check_eq("t1_xd_data_held", xd_data, 8'hA5);
    // Scan now starts at 3, so 3 beats 0.
    req_data = 32'h77000011; req_valid = 4'b1001;
    wait_grants(2, "t1b_grant");
    req_valid = 4'b0000;
    check_eq("t1b_next_is_3", last_g, 3);
    wait_dones(2, "t1b_done");

    // All four continuously valid.
    drop_on_ready = 1'b0; check_repeat = 1'b1;
    req_data = 32'h44332211; req_valid = 4'hF;
    base = grant_log.size();
    wait_dones(7, "t2_done");
    req_valid = 4'h0;
    check_repeat = 1'b0; drop_on_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_order", (grant_log.size() > base + i) ? grant_log[base + i] : -1, exp_seq[i]);
    end

    // Payload changes after the grant must not reach xd_data.
    req_data[15:8] = 8'h3C; req_valid = 4'b0010; check_stable = 1'b1;
    wait_grants(n_grant + 1, "t3_grant");
    req_data[15:8] = 8'hC3;
    wait_dones(8, "t3_done");
    repeat (3) step();
    check_eq("t3_hold_idle", xd_data, 8'h3C);
    check_stable = 1'b0;
    req_valid = 4'b0010;
    wait_dones(9, "t3b_done");
    check_eq("t3b_new_data", xd_data, 8'hC3);

    // Reset while in REQ.
    req_valid = 4'b0001;
    wait_grants(n_grant + 1, "t4_grant");
    check_eq("t4_in_req", xd_req, 1);
    rst = 1'b1;
    step();
    check_eq("t4_xd_req_drop", xd_req, 0);
    check_eq("t4_busy_drop", busy, 0);
    rst = 1'b0;
    clear_after_reset();
    base = n_done;
    repeat (12) step();
    check_eq("t4_no_done", n_done - base, 0);
    req_valid = 4'hF;
    wait_grants(n_grant + 1, "t4b_grant");
    req_valid = 4'h0;
    check_eq("t4_ptr_reset", last_g, 0);
    wait_dones(base + 1, "t4b_done");

    // Stale acknowledge across reset.
    auto_ack = 1'b0; xd_ack = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_after_reset();
    req_valid = 4'b0001; expect_no_grant = 1'b1;
    base = n_grant;
    repeat (8) step();
    check_eq("t5_no_grant", n_grant - base, 0);
    expect_no_grant = 1'b0;
    xd_ack = 1'b0;
    k = 0;
    while (n_grant == base && k < 20) begin step(); k++; end
    check_eq("t5_grant_latency", k, SYNC_DEPTH + 1);
    auto_ack = 1'b1;
    wait_dones(n_done + 1, "t5_done");

`ifdef CDC_HS_TIMEOUT_EN
    // Watchdog: far side never answers.
    auto_ack = 1'b0; xd_ack = 1'b0;
    base = n_done;
    req_valid = 4'b0101;
    k = 0;
    while (n_to < 1 && k < 100) begin step(); k++; end
    check_eq("t6_first_timeout", n_to, 1);
    wait_grants(n_grant + 1, "t6_next_grant");
    check_eq("t6_next_id", last_g, 0);
    k = 0;
    while (n_to < 2 && k < 100) begin step(); k++; end
    check_eq("t6_second_timeout", n_to, 2);
    check_eq("t6_no_done", n_done - base, 0);
    req_valid = 4'h0;
    auto_ack = 1'b1;
`endif

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
